alu_seq_arbiter: RTL and testbench

Sequencer and two-requester arbiter in front of the multi-cycle ALU. It accepts one operation at a time from requester 0 (main ID/EX issue) or requester 1 (auxiliary/branch-resolve unit). It drives the ALU operand/control inputs and pulses its one-cycle load strobe. It waits a fixed settle interval, then captures the ALU flags and result into a response register returned with the requester id and tag.

---
 rtl/alu_seq_pkg.sv | 18 +
 rtl/alu_seq_rr_arb.sv | 24 ++
 rtl/alu_seq_arbiter.sv | 148 ++++++++++++++
 tb/tb_alu_seq_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared states, ALU opcodes and branch codes for the ALU sequencer
package alu_seq_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, RESP} state_e;
  localparam int CNT_W = 4;
  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_BEQ  = 5'b00111;
  localparam logic [4:0] OP_BNE  = 5'b01110;
  localparam logic [4:0] OP_JALR = 5'b10001;
  localparam logic [4:0] OP_JAL  = 5'b10010;
  localparam logic [2:0] BR_NONE   = 3'd0;
  localparam logic [2:0] BR_PC_IMM = 3'd1;
  localparam logic [2:0] BR_JAL    = 3'd2;
  localparam logic [2:0] BR_JALR   = 3'd3;
endpackage

// File: rtl/alu_seq_rr_arb.sv
// alu_seq_rr_arb: 2-way grant with round-robin pointer, or fixed priority under ALU_SEQ_FIXED_PRIO_EN
module alu_seq_rr_arb (
`ifndef ALU_SEQ_FIXED_PRIO_EN
  input  logic       clk,
  input  logic       rst,
`endif
  input  logic       en,
  input  logic [1:0] req_valid,
  output logic [1:0] gnt,
  output logic       gnt_id
);
`ifdef ALU_SEQ_FIXED_PRIO_EN
  assign gnt_id = ~req_valid[0];
`else
  logic rr_ptr_q, rr_ptr_d;
  assign gnt_id   = (&req_valid) ? rr_ptr_q : req_valid[1];
  assign rr_ptr_d = (|gnt) ? ~gnt_id : rr_ptr_q;
  // pointer moves to the loser only when a grant is issued
  always_ff @(posedge clk or posedge rst)
    if (rst) rr_ptr_q <= 1'b0;
    else     rr_ptr_q <= rr_ptr_d;
`endif
  assign gnt = (en && |req_valid) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
endmodule

// File: rtl/alu_seq_arbiter.sv
// alu_seq_arbiter: two-requester sequencer for the multi-cycle ALU (ALU_SEQ_FIXED_PRIO_EN selects fixed priority)
module alu_seq_arbiter #(
  parameter int SETTLE_CYCLES = 4,
  parameter int TAG_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req0_b,
  input  logic [31:0]      req1_b,
  input  logic [4:0]       req0_ctrl,
  input  logic [4:0]       req1_ctrl,
  input  logic [31:0]      req0_pc,
  input  logic [31:0]      req1_pc,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [31:0]      alu_pc,
  output logic [4:0]       alu_ctrl,
  output logic             alu_tick,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  input  logic             alu_cout,
  input  logic             alu_overflow,
  input  logic [2:0]       alu_branch,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      rsp_result,
  output logic [2:0]       rsp_flags,
  output logic [2:0]       rsp_branch,
  output logic             busy
);
  import alu_seq_pkg::*;
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        a_q, a_d, b_q, b_d, pc_q, pc_d;
  logic [4:0]         ctrl_q, ctrl_d;
  logic [TAG_W-1:0]   tag_q, tag_d, rsp_tag_q, rsp_tag_d;
  logic               id_q, id_d, rsp_id_q, rsp_id_d;
  logic [31:0]        rsp_result_q, rsp_result_d;
  logic [2:0]         rsp_flags_q, rsp_flags_d, rsp_branch_q, rsp_branch_d;
  logic [1:0]         gnt;
  logic               gnt_id;
  alu_seq_rr_arb u_arb (
`ifndef ALU_SEQ_FIXED_PRIO_EN
    .clk       (clk),
    .rst       (rst),
`endif
    .en        (state_q == IDLE && !rst),
    .req_valid (req_valid),
    .gnt       (gnt),
    .gnt_id    (gnt_id)
  );
  assign req_ready  = gnt;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_pc     = pc_q;
  assign alu_ctrl   = ctrl_q;
  assign alu_tick   = state_q == ISSUE;
  assign rsp_valid  = state_q == RESP;
  assign busy       = state_q != IDLE;
  assign rsp_id     = rsp_id_q;
  assign rsp_tag    = rsp_tag_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_branch = rsp_branch_q;
  // latch the winner, pulse the ALU, count out the settle interval, hold the response
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    pc_d         = pc_q;
    ctrl_d       = ctrl_q;
    tag_d        = tag_q;
    id_d         = id_q;
    rsp_id_d     = rsp_id_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_branch_d = rsp_branch_q;
    case (state_q)
      IDLE: if (|gnt) begin
        state_d = ISSUE;
        a_d     = gnt_id ? req1_a    : req0_a;
        b_d     = gnt_id ? req1_b    : req0_b;
        pc_d    = gnt_id ? req1_pc   : req0_pc;
        ctrl_d  = gnt_id ? req1_ctrl : req0_ctrl;
        tag_d   = gnt_id ? req1_tag  : req0_tag;
        id_d    = gnt_id;
      end
      ISSUE: begin
        cnt_d   = CNT_W'(SETTLE_CYCLES);
        state_d = SETTLE;
      end
      SETTLE: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d      = RESP;
          rsp_id_d     = id_q;
          rsp_tag_d    = tag_q;
          rsp_result_d = alu_result;
          rsp_flags_d  = {alu_overflow, alu_cout, alu_zero};
          rsp_branch_d = alu_branch;
        end
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      pc_q         <= '0;
      ctrl_q       <= '0;
      tag_q        <= '0;
      id_q         <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_tag_q    <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_branch_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      pc_q         <= pc_d;
      ctrl_q       <= ctrl_d;
      tag_q        <= tag_d;
      id_q         <= id_d;
      rsp_id_q     <= rsp_id_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_branch_q <= rsp_branch_d;
    end
endmodule

// File: tb/tb_alu_seq_arbiter.sv
// tb_alu_seq_arbiter: scoreboard bench with a three-stage ALU model behind the sequencer
module tb_alu_seq_arbiter;
  import alu_seq_pkg::*;
  localparam int SC = 4;
  localparam int TW = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] req_valid = '0, req_ready;
  logic [31:0] req0_a = '0, req1_a = '0, req0_b = '0, req1_b = '0, req0_pc = '0, req1_pc = '0;
  logic [4:0] req0_ctrl = '0, req1_ctrl = '0;
  logic [TW-1:0] req0_tag = '0, req1_tag = '0;
  logic [31:0] alu_a, alu_b, alu_pc;
  logic [4:0] alu_ctrl;
  logic alu_tick;
  logic rsp_valid, rsp_ready = 1'b1, rsp_id, busy;
  logic [TW-1:0] rsp_tag;
  logic [31:0] rsp_result;
  logic [2:0] rsp_flags, rsp_branch;
  logic [37:0] s1 = '0, s2 = '0;
  logic [2:0] s3 = '0;
  typedef struct {logic id; logic [TW-1:0] tag; logic [31:0] res; logic [2:0] fl; logic [2:0] br;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int total = 0, passed = 0;

  alu_seq_arbiter #(.SETTLE_CYCLES(SC), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
    .req0_ctrl(req0_ctrl), .req1_ctrl(req1_ctrl), .req0_pc(req0_pc), .req1_pc(req1_pc),
    .req0_tag(req0_tag), .req1_tag(req1_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_pc(alu_pc), .alu_ctrl(alu_ctrl), .alu_tick(alu_tick),
    .alu_result(s2[31:0]), .alu_zero(s2[32]), .alu_cout(s2[33]), .alu_overflow(s2[34]),
    .alu_branch(s3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_branch(rsp_branch), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [37:0] alu_f(input logic [31:0] a, b, pc, input logic [4:0] ctrl);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    logic [2:0] br;
    r = '0; c = 1'b0; v = 1'b0; br = BR_NONE; s = '0;
    case (ctrl)
      OP_ADD: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32]; v = (a[31] == b[31]) && (r[31] != a[31]); end
      OP_SUB: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; c = s[32]; v = (a[31] != b[31]) && (r[31] != a[31]); end
      OP_BEQ: begin r = {31'b0, a == b}; br = (a == b) ? BR_PC_IMM : BR_NONE; end
      OP_BNE: begin r = {31'b0, a != b}; br = (a != b) ? BR_PC_IMM : BR_NONE; end
      OP_JAL: begin r = pc + 32'd4; br = BR_JAL; end
      default: r = '0;
    endcase
    return {br, v, c, r == 32'd0, r};
  endfunction

  // ALU model: operands taken on tick, result/flags one edge later, branch code one edge after that
  always @(posedge clk) begin
    if (alu_tick) s1 <= alu_f(alu_a, alu_b, alu_pc, alu_ctrl);
    s2 <= s1;
    s3 <= s2[37:35];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // monitor: every response handshake is compared against the oldest expectation
  always @(negedge clk)
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL rsp_unexpected: got tag 0x%0h result 0x%0h, want no response", rsp_tag, rsp_result);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(mon_e.id));
        chk("rsp_tag", 32'(rsp_tag), 32'(mon_e.tag));
        chk("rsp_result", rsp_result, mon_e.res);
        chk("rsp_flags", 32'(rsp_flags), 32'(mon_e.fl));
        chk("rsp_branch", 32'(rsp_branch), 32'(mon_e.br));
      end
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int r, input logic [31:0] a, b, pc, input logic [4:0] ctrl, input logic [TW-1:0] tag,
                       input logic [31:0] res, input logic [2:0] fl, br, input bit push);
    bit granted;
    granted = 1'b0;
    if (r == 0) begin req0_a = a; req0_b = b; req0_pc = pc; req0_ctrl = ctrl; req0_tag = tag; end
    else begin req1_a = a; req1_b = b; req1_pc = pc; req1_ctrl = ctrl; req1_tag = tag; end
    req_valid[r] = 1'b1;
    for (int n = 0; n < 64 && !granted; n++) begin
      #1;
      if (req_ready[r]) granted = 1'b1;
      else step();
    end
    chk("grant_seen", 32'(granted), 32'd1);
    if (push) sb.push_back('{r[0], tag, res, fl, br});
    step();
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 100 && busy; n++) step();
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin
    int n;
    logic exp_id;
    bit found;
    req_valid = 2'b11;
    #2;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_tick", 32'(alu_tick), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    req_valid = 2'b00;
    step(); step();
    rst = 1'b0;
    step();
    // single ADD from requester 0 with latency check
    issue(0, 32'd5, 32'd7, 32'd0, OP_ADD, 4'd3, 32'd12, 3'b000, BR_NONE, 1'b1);
    chk("t1_tick", 32'(alu_tick), 32'd1);
    chk("t1_alu_a", alu_a, 32'd5);
    chk("t1_alu_b", alu_b, 32'd7);
    n = 0;
    while (!rsp_valid && n < 20) begin step(); n++; if (alu_tick) chk("t1_tick_once", 32'(alu_tick), 32'd0); end
    chk("t1_latency", 32'(n), 32'(SC + 1));
    wait_idle();
    // branch compares from requester 1
    issue(1, 32'd9, 32'd9, 32'd0, OP_BEQ, 4'd1, 32'd1, 3'b000, BR_PC_IMM, 1'b1);
    wait_idle();
    issue(1, 32'd9, 32'd9, 32'd0, OP_BNE, 4'd2, 32'd0, 3'b001, BR_NONE, 1'b1);
    wait_idle();
    // both requesters continuously valid
    req0_a = 32'd10; req0_b = 32'd1;   req0_ctrl = OP_ADD; req0_tag = 4'd4; req0_pc = '0;
    req1_a = 32'd10; req1_b = 32'd100; req1_ctrl = OP_ADD; req1_tag = 4'd5; req1_pc = '0;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      found = 1'b0;
      for (int m = 0; m < 64 && !found; m++) begin
        #1;
        if (|req_ready) found = 1'b1;
        else step();
      end
`ifdef ALU_SEQ_FIXED_PRIO_EN
      exp_id = 1'b0;
`else
      exp_id = k[0];
`endif
      chk("t3_grant", 32'(req_ready), exp_id ? 32'd2 : 32'd1);
      sb.push_back('{exp_id, exp_id ? 4'd5 : 4'd4, exp_id ? 32'd110 : 32'd11, 3'b000, BR_NONE});
      step();
    end
    req_valid = 2'b00;
    wait_idle();
    // response held under back-pressure
    rsp_ready = 1'b0;
    issue(0, 32'd20, 32'd22, 32'd0, OP_ADD, 4'd6, 32'd42, 3'b000, BR_NONE, 1'b1);
    for (n = 0; n < 20 && !rsp_valid; n++) step();
    chk("t4_rsp_seen", 32'(rsp_valid), 32'd1);
    req1_ctrl = OP_ADD; req1_tag = 4'd15;
    req_valid = 2'b10;
    #1;
    for (int k = 0; k < 10; k++) begin
      chk("t4_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t4_hold_result", rsp_result, 32'd42);
      chk("t4_hold_tag", 32'(rsp_tag), 32'd6);
      chk("t4_hold_ready", 32'(req_ready), 32'd0);
      chk("t4_hold_tick", 32'(alu_tick), 32'd0);
      step();
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    step();
    chk("t4_release_busy", 32'(busy), 32'd0);
    chk("t4_release_valid", 32'(rsp_valid), 32'd0);
    chk("t4_keep_result", rsp_result, 32'd42);
    // asynchronous reset in the middle of settling
    issue(0, 32'h55, 32'd1, 32'd0, OP_ADD, 4'hA, 32'd0, 3'b000, BR_NONE, 1'b0);
    step(); step();
    #2;
    rst = 1'b1;
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_tick", 32'(alu_tick), 32'd0);
    chk("t5_alu_a", alu_a, 32'd0);
    chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_rsp_result", rsp_result, 32'd0);
    for (int k = 0; k < 3; k++) step();
    rst = 1'b0;
    for (int k = 0; k < SC + 4; k++) begin
      step();
      if (alu_tick || busy) chk("t5_quiet", {30'd0, alu_tick, busy}, 32'd0);
    end
    chk("t5_idle_after", 32'(busy), 32'd0);
    issue(0, 32'd3, 32'd5, 32'd0, OP_SUB, 4'd9, 32'hFFFF_FFFE, 3'b000, BR_NONE, 1'b1);
    wait_idle();
    // JAL link value and signed overflow
    issue(1, 32'd0, 32'd0, 32'h100, OP_JAL, 4'd7, 32'h104, 3'b000, BR_JAL, 1'b1);
    wait_idle();
    issue(0, 32'h7FFF_FFFF, 32'd1, 32'd0, OP_ADD, 4'd8, 32'h8000_0000, 3'b100, BR_NONE, 1'b1);
    wait_idle();
    step();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
